// File: rtl/ram_test.sv
// RAM exerciser: writes P(a) over 0..LAST_ADDR through the data port, reads it back
// through the data port, then through the instruction port; stops on the first mismatch.
module ram_test #(
  parameter logic [25:0] LAST_ADDR = 26'h0003FF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_stb,
  output logic [25:0] inst_addr,
  input  logic [63:0] inst_din,
  input  logic        inst_ack,
  output logic        data_stb,
  output logic        data_we,
  output logic [25:0] data_addr,
  output logic [63:0] data_dout,
  input  logic [63:0] data_din,
  input  logic        data_ack,
  output logic        test_ended,
  output logic        test_error
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] RDD     = 3'd2;
  localparam logic [2:0] RDI     = 3'd3;
  localparam logic [2:0] GAP_WR  = 3'd4;
  localparam logic [2:0] GAP_RDD = 3'd5;
  localparam logic [2:0] GAP_RDI = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [25:0] addr_q, addr_d;
  logic        error_q, error_d;
  logic        at_last;

  function automatic logic [63:0] pattern(input logic [25:0] a);
    pattern = {~{6'b0, a}, {6'b0, a}};
  endfunction

  assign at_last = (addr_q == LAST_ADDR);

  // Acks are only looked at in the access state of their own port.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    error_d = error_q;
    case (state_q)
      IDLE:    state_d = WR;
      WR: begin
        if (data_ack) begin
          if (at_last) begin
            addr_d  = '0;
            state_d = GAP_RDD;
          end else begin
            addr_d  = addr_q + 26'd1;
            state_d = GAP_WR;
          end
        end
      end
      RDD: begin
        if (data_ack) begin
          if (data_din != pattern(addr_q)) begin
            error_d = 1'b1;
            state_d = DONE;
          end else if (at_last) begin
            addr_d  = '0;
            state_d = GAP_RDI;
          end else begin
            addr_d  = addr_q + 26'd1;
            state_d = GAP_RDD;
          end
        end
      end
      RDI: begin
        if (inst_ack) begin
          if (inst_din != pattern(addr_q)) begin
            error_d = 1'b1;
            state_d = DONE;
          end else if (at_last) begin
            addr_d  = '0;
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 26'd1;
            state_d = GAP_RDI;
          end
        end
      end
      GAP_WR:  state_d = WR;
      GAP_RDD: state_d = RDD;
      GAP_RDI: state_d = RDI;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      error_q <= error_d;
    end
  end

  assign data_stb   = (state_q == WR) || (state_q == RDD);
  assign data_we    = (state_q == WR);
  assign inst_stb   = (state_q == RDI);
  assign inst_addr  = addr_q;
  assign data_addr  = addr_q;
  assign data_dout  = pattern(addr_q);
  assign test_ended = (state_q == DONE);
  assign test_error = error_q;

endmodule

// File: tb/tb_ram_test.sv
// Bench for ram_test: a memory responder with configurable latency, corruption,
// timeouts and stray acks, checked against the expected access sequence.
module tb_ram_test;

  typedef struct packed {
    logic [1:0]  kind;   // 0 write, 1 data read, 2 inst read
    logic [25:0] addr;
    logic [63:0] dout;
  } acc_t;

  logic        clk, rst;
  logic        inst_stb, inst_ack, data_stb, data_we, data_ack;
  logic [25:0] inst_addr, data_addr;
  logic [63:0] inst_din, data_dout, data_din;
  logic        test_ended, test_error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // responder configuration
  int          ack_delay = 0;
  bit          rand_lat = 0, tmo = 0, spur = 0, cor_d_en = 0, cor_i_en = 0;
  logic [25:0] cor_d_addr = '0, cor_i_addr = '0;
  logic [63:0] cor_mask = 64'h1;

  // responder observations
  logic [63:0] mem [0:1023];
  acc_t        log_q[$];
  int          both_viol, gap_viol, unstable, post_end, err_early, istb_cnt;
  int          min_len, max_len, last_ack_cyc, end_cyc, rel_cyc;
  int          wait_cnt = 0, cur_delay = 0;
  bit          prev_ack = 0;
  logic        stb;
  logic [118:0] cap;
  logic [25:0] a;

  ram_test dut (
    .clk(clk), .rst(rst),
    .inst_stb(inst_stb), .inst_addr(inst_addr), .inst_din(inst_din), .inst_ack(inst_ack),
    .data_stb(data_stb), .data_we(data_we), .data_addr(data_addr), .data_dout(data_dout),
    .data_din(data_din), .data_ack(data_ack),
    .test_ended(test_ended), .test_error(test_error)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [63:0] pat(input int addr);
    logic [31:0] lo;
    lo = addr;
    return {32'hFFFF_FFFF - lo, lo};
  endfunction

  function automatic logic [120:0] out_vec();
    return {inst_stb, data_stb, data_we, test_ended, test_error, data_dout, data_addr, inst_addr};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Memory model: acks after the configured latency, sampled away from the rising edge.
  initial forever begin
    @(negedge clk);
    data_ack = 1'b0;
    inst_ack = 1'b0;
    if (rst) begin
      wait_cnt = 0;
      prev_ack = 1'b0;
    end else begin
      stb = data_stb | inst_stb;
      if (data_stb && inst_stb) both_viol++;
      if (inst_stb) istb_cnt++;
      if (test_ended && stb) post_end++;
      if (test_error && !test_ended) err_early++;
      if (stb && prev_ack) gap_viol++;
      prev_ack = 1'b0;
      if (stb) begin
        if (wait_cnt == 0) begin
          cap = {data_stb, inst_stb, data_we, data_addr, inst_addr, data_dout};
          cur_delay = rand_lat ? int'($urandom_range(0, 3)) : ack_delay;
        end else if (cap !== {data_stb, inst_stb, data_we, data_addr, inst_addr, data_dout}) begin
          unstable++;
        end
        if (wait_cnt == cur_delay) begin
          a = inst_stb ? inst_addr : data_addr;
          if (tmo) begin
            if (data_stb) begin data_ack = 1'b1; data_din = '0; end
            else begin inst_ack = 1'b1; inst_din = '0; end
          end else if (data_stb && data_we) begin
            mem[a[9:0]] = data_dout;
            data_ack = 1'b1;
          end else if (data_stb) begin
            data_din = mem[a[9:0]];
            if (cor_d_en && a == cor_d_addr) data_din = data_din ^ cor_mask;
            data_ack = 1'b1;
          end else begin
            inst_din = mem[a[9:0]];
            if (cor_i_en && a == cor_i_addr) inst_din = '0;
            inst_ack = 1'b1;
          end
          log_q.push_back('{kind: (data_stb ? (data_we ? 2'd0 : 2'd1) : 2'd2),
                            addr: a, dout: data_dout});
          if (wait_cnt + 1 < min_len) min_len = wait_cnt + 1;
          if (wait_cnt + 1 > max_len) max_len = wait_cnt + 1;
          last_ack_cyc = cyc;
          prev_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      // stray acks on a port that has no request outstanding must be ignored
      if (spur) begin
        if (!data_stb && $urandom_range(0, 3) == 0) begin
          data_ack = 1'b1;
          data_din = {$urandom, $urandom};
        end
        if (!inst_stb && $urandom_range(0, 3) == 0) begin
          inst_ack = 1'b1;
          inst_din = {$urandom, $urandom};
        end
      end
    end
  end

  task automatic run_full(input string nm, input int nw, input int nd, input int ni,
                          input logic exp_err);
    int n, bad, cw, cd, ci, ke, ae;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    log_q.delete();
    both_viol = 0; gap_viol = 0; unstable = 0; post_end = 0; err_early = 0; istb_cnt = 0;
    min_len = 1000; max_len = 0; last_ack_cyc = -10;
    @(negedge clk);
    check({nm, "_reset"}, out_vec(), {5'b0, pat(0), 26'd0, 26'd0});
    rst = 1'b0;
    rel_cyc = cyc;
    @(negedge clk);
    check({nm, "_first_stb"}, {data_stb, data_we, inst_stb, data_addr}, {3'b110, 26'd0});
    n = 1;
    while (!test_ended && n < 40000) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_ended"}, test_ended, 1'b1);
    check({nm, "_error"}, test_error, exp_err);
    end_cyc = cyc;
    repeat (10) @(negedge clk);
    cw = 0; cd = 0; ci = 0; bad = 0;
    foreach (log_q[i]) begin
      if (log_q[i].kind == 2'd0) cw++;
      else if (log_q[i].kind == 2'd1) cd++;
      else ci++;
      ke = (i < nw) ? 0 : ((i < nw + nd) ? 1 : 2);
      ae = (ke == 0) ? i : ((ke == 1) ? i - nw : i - nw - nd);
      if (log_q[i].kind != 2'(ke) || log_q[i].addr != 26'(ae) || log_q[i].dout != pat(ae))
        bad++;
    end
    check({nm, "_counts"}, {32'(cw), 32'(cd), 32'(ci)}, {32'(nw), 32'(nd), 32'(ni)});
    check({nm, "_sequence"}, bad, 0);
    check({nm, "_protocol"}, {32'(post_end), 32'(both_viol), 32'(gap_viol), 32'(unstable)}, 128'd0);
    check({nm, "_err_with_end"}, err_early, 0);
  endtask

  initial begin
    int n;
    acc_t e;
    bit got;
    rst = 1'b1;
    data_ack = 1'b0; inst_ack = 1'b0;
    data_din = '0; inst_din = '0;
    repeat (2) @(negedge clk);

    // zero-wait pass: test_ended visible in clock 1 + 3*2*1024 counting the IDLE clock as 1
    run_full("zw", 1024, 1024, 1024, 1'b0);
    check("zw_end_clock", end_cyc - rel_cyc + 1, 1 + 3 * 2 * 1024);

    // data read at 0x155 corrupted with a random nonzero mask
    cor_mask = {$urandom, $urandom};
    if (cor_mask == '0) cor_mask = 64'h1;
    cor_d_en = 1; cor_d_addr = 26'h155;
    run_full("d155", 1024, 'h156, 0, 1'b1);
    check("d155_err_timing", end_cyc, last_ack_cyc + 1);
    check("d155_no_inst_stb", istb_cnt, 0);
    cor_d_en = 0;

    // inst read at the last address returns zero
    cor_i_en = 1; cor_i_addr = 26'h3FF;
    run_full("i3ff", 1024, 1024, 1024, 1'b1);
    check("i3ff_err_timing", end_cyc, last_ack_cyc + 1);
    cor_i_en = 0;

    // every ack 7 cycles late
    ack_delay = 7;
    run_full("dly7", 1024, 1024, 1024, 1'b0);
    check("dly7_stb_len", {32'(min_len), 32'(max_len)}, {32'd8, 32'd8});
    ack_delay = 0;

    // reset while writing 0x80
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n = 0;
    while (!(data_stb && data_we && data_addr == 26'h80) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_reach", {data_stb, data_we, data_addr}, {2'b11, 26'h80});
    rst = 1'b1;
    #1;
    check("rstmid_async", out_vec(), {5'b0, pat(0), 26'd0, 26'd0});
    @(negedge clk);
    log_q.delete();
    rst = 1'b0;
    n = 0;
    while (log_q.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    got = (log_q.size() > 0);
    e = '0;
    if (got) e = log_q[0];
    check("rstmid_restart", {got, e.kind, e.addr}, {1'b1, 2'd0, 26'd0});

    // controller answers only with timeouts carrying zero data
    tmo = 1;
    run_full("tmo", 1024, 1, 0, 1'b1);
    tmo = 0;

    // random latency, stray acks, random corrupted data-read address
    rand_lat = 1; spur = 1;
    cor_d_en = 1; cor_d_addr = 26'($urandom_range(0, 1023));
    cor_mask = {$urandom, $urandom} | 64'h1;
    run_full("rnd", 1024, int'(cor_d_addr) + 1, 0, 1'b1);
    check("rnd_err_timing", end_cyc, last_ack_cyc + 1);
    rand_lat = 0; spur = 0; cor_d_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
